// File: rtl/des_block_feeder_pkg.sv
// Shared widths and word-order definitions for the DES block datapath
// (feeder, output-side unpacker and stepper).
package des_block_feeder_pkg;

    localparam int DES_BLK_W      = 64;
    localparam int PIPE_W         = 32;
    localparam bit LOW_WORD_FIRST = 1'b1;

    typedef logic [DES_BLK_W-1:0] desBlock_t;

    // Assemble a block from two PipeIn words in arrival order.
    function automatic desBlock_t packBlock(input logic [PIPE_W-1:0] firstWord,
                                            input logic [PIPE_W-1:0] secondWord);
        desBlock_t blk;
        if (LOW_WORD_FIRST) begin
            blk = {secondWord, firstWord};
        end else begin
            blk = {firstWord, secondWord};
        end
        return blk;
    endfunction

endpackage

// File: rtl/des_blk_fifo_mem.sv
// Simple dual-port block storage: one write port, one registered read port,
// shaped so synthesis maps it onto block RAM.
module des_blk_fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) (
    input  logic              okClk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

    // Write port.
    always_ff @(posedge okClk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    // Registered read port; returns the old contents on a same-address write.
    always_ff @(posedge okClk) begin
        if (rdEn) begin
            rdData <= mem_r[rdAddr];
        end
    end

endmodule

// File: rtl/des_block_feeder.sv
// Packs 32-bit PipeIn words into 64-bit DES blocks, buffers them in a FIFO
// and presents them to the stepper through a show-ahead valid/ready register.
module des_block_feeder
    import des_block_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 okClk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 pipe_write,
    input  logic [PIPE_W-1:0]    pipe_data,
    output logic                 blk_valid,
    output logic [DES_BLK_W-1:0] blk_data,
    input  logic                 blk_ready,
    output logic [DEPTH_LOG2:0]  level,
    output logic                 half_pending,
    output logic                 overflow
);

    localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [PIPE_W-1:0]     lowWord_r;
    logic [DEPTH_LOG2-1:0] wrPtr_r;
    logic [DEPTH_LOG2-1:0] rdPtr_r;
    logic                  rdPend_r;
    logic [DES_BLK_W-1:0]  rdData_s;
    logic                  clr_s;
    logic                  pushReq_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  moveOut_s;

    // Handshake decisions; a pop only happens when the output stage will be free.
    always_comb begin
        clr_s     = reset | flush;
        pushReq_s = pipe_write & half_pending;
        pop_s     = (level != LEVEL_ZERO) && (!blk_valid || blk_ready);
        moveOut_s = rdPend_r && (!blk_valid || blk_ready);
        if (pushReq_s && ((level != LEVEL_FULL) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        drop_s = pushReq_s & ~push_s;
    end

    des_blk_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (DES_BLK_W)
    ) uMem (
        .okClk  (okClk),
        .wrEn   (push_s & ~clr_s),
        .wrAddr (wrPtr_r),
        .wrData (packBlock(lowWord_r, pipe_data)),
        .rdEn   (pop_s & ~clr_s),
        .rdAddr (rdPtr_r),
        .rdData (rdData_s)
    );

    // Word packer: alternate between holding the first word and completing the pair.
    always_ff @(posedge okClk) begin
        if (clr_s) begin
            lowWord_r    <= {PIPE_W{1'b0}};
            half_pending <= 1'b0;
        end else if (pipe_write) begin
            if (!half_pending) begin
                lowWord_r    <= pipe_data;
                half_pending <= 1'b1;
            end else begin
                half_pending <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge okClk) begin
        if (clr_s) begin
            wrPtr_r  <= {DEPTH_LOG2{1'b0}};
            rdPtr_r  <= {DEPTH_LOG2{1'b0}};
            level    <= LEVEL_ZERO;
            overflow <= 1'b0;
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output register fed from the RAM read stage; the read stage holds its data
    // until the output register can take it, so the output can move a block per cycle.
    always_ff @(posedge okClk) begin
        if (clr_s) begin
            rdPend_r  <= 1'b0;
            blk_valid <= 1'b0;
            blk_data  <= {DES_BLK_W{1'b0}};
        end else begin
            if (pop_s) begin
                rdPend_r <= 1'b1;
            end else if (moveOut_s) begin
                rdPend_r <= 1'b0;
            end
            if (moveOut_s) begin
                blk_data  <= rdData_s;
                blk_valid <= 1'b1;
            end else if (blk_valid && blk_ready) begin
                blk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_block_feeder.sv
// Self-checking bench for des_block_feeder: directed boundary scenarios plus a
// randomized stream, checked against a queue-based model of the block stream.
module tb_des_block_feeder;

    logic        okClk = 1'b0;
    logic        reset;
    logic        flush;
    logic        pipe_write;
    logic [31:0] pipe_data;
    logic        blk_valid;
    logic [63:0] blk_data;
    logic        blk_ready;
    logic [4:0]  level;
    logic        half_pending;
    logic        overflow;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [63:0] expQ[$];

    localparam int CAPACITY = 17;

    always #5 okClk = ~okClk;

    des_block_feeder #(.DEPTH_LOG2(4)) dut (
        .okClk        (okClk),
        .reset        (reset),
        .flush        (flush),
        .pipe_write   (pipe_write),
        .pipe_data    (pipe_data),
        .blk_valid    (blk_valid),
        .blk_data     (blk_data),
        .blk_ready    (blk_ready),
        .level        (level),
        .half_pending (half_pending),
        .overflow     (overflow)
    );

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic writeWord(input logic [31:0] w);
        pipe_write = 1'b1;
        pipe_data  = w;
        tick();
        pipe_write = 1'b0;
    endtask

    // Stalled consumer: the model holds at most FIFO depth + output register.
    task automatic stallPush(input logic [31:0] lo, input logic [31:0] hi);
        writeWord(lo);
        writeWord(hi);
        if (expQ.size() < CAPACITY) expQ.push_back({hi, lo});
    endtask

    task automatic checkAllClear(input string tag);
        checkEq({tag, "_valid"}, 64'(blk_valid), 64'd0);
        checkEq({tag, "_data"}, blk_data, 64'd0);
        checkEq({tag, "_level"}, 64'(level), 64'd0);
        checkEq({tag, "_half"}, 64'(half_pending), 64'd0);
        checkEq({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    task automatic drainCheck(input string tag);
        int budget = 300;
        blk_ready = 1'b1;
        while (expQ.size() != 0 && budget > 0) begin
            if (blk_valid) checkEq({tag, "_blk"}, blk_data, expQ.pop_front());
            tick();
            budget--;
        end
        checkEq({tag, "_left"}, 64'(expQ.size()), 64'd0);
        repeat (4) tick();
        checkEq({tag, "_extra"}, 64'(blk_valid), 64'd0);
        blk_ready = 1'b0;
        expQ.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w1, w2, w3, lo, hi, base;
        int          wordIdx, got, cyc;

        reset = 1'b1; flush = 1'b0; pipe_write = 1'b0; pipe_data = 32'd0; blk_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        checkAllClear("rst");

        // Basic pair and latency.
        writeWord(32'h0123_4567);
        checkEq("t1_half", 64'(half_pending), 64'd1);
        writeWord(32'h89AB_CDEF);
        checkEq("t1_levelN", 64'(level), 64'd1);
        checkEq("t1_validN", 64'(blk_valid), 64'd0);
        tick();
        checkEq("t1_validN1", 64'(blk_valid), 64'd0);
        tick();
        checkEq("t1_validN2", 64'(blk_valid), 64'd1);
        checkEq("t1_data", blk_data, 64'h89AB_CDEF_0123_4567);
        checkEq("t1_halfclr", 64'(half_pending), 64'd0);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        checkEq("t1_consumed", 64'(blk_valid), 64'd0);

        // Half word discarded by flush.
        w1 = $urandom; w2 = $urandom; w3 = $urandom;
        writeWord(w1);
        checkEq("t2_half", 64'(half_pending), 64'd1);
        checkEq("t2_level", 64'(level), 64'd0);
        checkEq("t2_valid", 64'(blk_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkEq("t2_flushhalf", 64'(half_pending), 64'd0);
        writeWord(w2);
        writeWord(w3);
        expQ.push_back({w3, w2});
        drainCheck("t2");

        // Fill to capacity, then drop one.
        for (int i = 0; i < 17; i++) stallPush($urandom, $urandom);
        repeat (2) tick();
        checkEq("t3_valid", 64'(blk_valid), 64'd1);
        checkEq("t3_level", 64'(level), 64'd16);
        checkEq("t3_ovf0", 64'(overflow), 64'd0);
        stallPush($urandom, $urandom);
        checkEq("t3_leveldrop", 64'(level), 64'd16);
        checkEq("t3_ovf1", 64'(overflow), 64'd1);
        drainCheck("t3");
        checkEq("t3_sticky", 64'(overflow), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkEq("t3_ovfclr", 64'(overflow), 64'd0);

        // Full FIFO with a pop coincident with the push.
        for (int i = 0; i < 17; i++) stallPush($urandom, $urandom);
        repeat (2) tick();
        checkEq("t4_level", 64'(level), 64'd16);
        lo = $urandom; hi = $urandom;
        writeWord(lo);
        pipe_write = 1'b1;
        pipe_data  = hi;
        blk_ready  = 1'b1;
        checkEq("t4_front", blk_data, expQ.pop_front());
        expQ.push_back({hi, lo});
        tick();
        pipe_write = 1'b0;
        blk_ready  = 1'b0;
        checkEq("t4_levelkeep", 64'(level), 64'd16);
        checkEq("t4_ovf", 64'(overflow), 64'd0);
        drainCheck("t4");

        // Counter-based stream with ready toggling every cycle.
        base = $urandom;
        wordIdx = 0; got = 0; cyc = 0;
        while (got < 40 && cyc < 3000) begin
            blk_ready = ~blk_ready;
            if (wordIdx < 80 && $urandom_range(0, 3) != 0) begin
                pipe_write = 1'b1;
                pipe_data  = base + 32'(wordIdx);
                wordIdx++;
            end else begin
                pipe_write = 1'b0;
            end
            if (blk_valid && blk_ready) begin
                lo = base + 32'(2 * got);
                hi = lo + 32'd1;
                checkEq("t5_blk", blk_data, {hi, lo});
                got++;
            end
            tick();
            cyc++;
        end
        pipe_write = 1'b0;
        blk_ready  = 1'b0;
        repeat (4) tick();
        checkEq("t5_count", 64'(got), 64'd40);
        checkEq("t5_ovf", 64'(overflow), 64'd0);
        checkEq("t5_level", 64'(level), 64'd0);
        checkEq("t5_valid", 64'(blk_valid), 64'd0);

        // Reset in the middle of a backlog.
        for (int i = 0; i < 6; i++) stallPush($urandom, $urandom);
        repeat (2) tick();
        checkEq("t6_level", 64'(level), 64'd5);
        checkEq("t6_valid", 64'(blk_valid), 64'd1);
        reset      = 1'b1;
        pipe_write = 1'b1;
        pipe_data  = $urandom;
        tick();
        reset      = 1'b0;
        pipe_write = 1'b0;
        checkAllClear("t6_rst");
        expQ.delete();
        stallPush($urandom, $urandom);
        drainCheck("t6");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
